// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO writes.
// Latency: MULT/DIV results land WIDTH+1 edges after the accepting edge; MTHI/MTLO land on the accepting edge.
// Backpressure: busy is high while an op is in flight; start is only taken in IDLE and never queued.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] u_reg;    // product upper half / partial remainder
  logic [WIDTH-1:0] l_reg;    // multiplier bits / dividend bits becoming quotient
  logic             is_div;
  logic             neg_q;    // negate product or quotient at the end
  logic             neg_r;    // negate remainder (dividend was negative)
  logic             div0;
  logic [CW-1:0]    cnt;

  // Operand decode: op[2]==0 is arithmetic, op[0]==0 selects the signed flavour.
  logic             arith_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Magnitudes and sign flags of the incoming operands.
  always_comb begin
    arith_op = ~op[2];
    a_neg    = ~op[0] & src_a[WIDTH-1];
    b_neg    = ~op[0] & src_b[WIDTH-1];
    a_mag    = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag    = b_neg ? (~src_b + 1'b1) : src_b;
  end

  // One multiply or divide iteration; sums are one bit wider so no carry or borrow is lost.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] u_nxt;
  logic [WIDTH-1:0] l_nxt;

  always_comb begin
    mul_sum   = {1'b0, u_reg} + (l_reg[0] ? {1'b0, m_reg} : '0);
    div_shift = {u_reg, l_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_reg};
    u_nxt     = u_reg;
    l_nxt     = l_reg;
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        u_nxt = div_diff[WIDTH-1:0];
        l_nxt = {l_reg[WIDTH-2:0], 1'b1};
      end else begin
        u_nxt = div_shift[WIDTH-1:0];
        l_nxt = {l_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      u_nxt = mul_sum[WIDTH:1];
      l_nxt = {mul_sum[0], l_reg[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes; a zero divisor forces an all-ones quotient.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  always_comb begin
    prod_fix = neg_q ? (~{u_reg, l_reg} + 1'b1) : {u_reg, l_reg};
    q_fix    = div0 ? '1 : (neg_q ? (~l_reg + 1'b1) : l_reg);
    r_fix    = neg_r ? (~u_reg + 1'b1) : u_reg;
    hi_res   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = is_div ? q_fix : prod_fix[WIDTH-1:0];
  end

  assign busy = (state != S_IDLE);

  // Control FSM plus datapath registers; flush overrides everything and drops the op silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      m_reg  <= '0;
      u_reg  <= '0;
      l_reg  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && arith_op) begin
              state  <= S_CALC;
              cnt    <= '0;
              is_div <= op[1];
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              div0   <= op[1] && (src_b == '0);
              m_reg  <= op[1] ? b_mag : a_mag;
              l_reg  <= op[1] ? a_mag : b_mag;
              u_reg  <= '0;
            end else if (start && op == 3'b100) begin
              hi <= src_a;
            end else if (start && op == 3'b101) begin
              lo <= src_a;
            end
          end
          S_CALC: begin
            u_reg <= u_nxt;
            l_reg <= l_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= S_FIX;
            end
          end
          S_FIX: begin
            hi    <= hi_res;
            lo    <= lo_res;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic results, latency, MTHI/MTLO, flush and reset.
// Expected values are hand-computed constants; the bench tracks the HI/LO it expects to be held.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          flush;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int            n_vec = 0;
  int            n_err = 0;
  logic [W-1:0]  exp_hi = '0;
  logic [W-1:0]  exp_lo = '0;
  int            done_cnt;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op, optionally poke a stray MTHI while busy, and check result and timing.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input bit inject);
    int k;
    bit seen;
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (inject && k == 5) begin
        op = 3'b100; src_a = 32'hDEADBEEF; start = 1'b1;
      end
      tick();
      k++;
      start = 1'b0;
      if (k == 10) chk({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
      if (done) seen = 1'b1;
    end
    chk({tag, "_lat"}, 64'(k), 64'(W + 1));
    chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    exp_hi = ehi;
    exp_lo = elo;
    tick();
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
    #2;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'({busy, done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Signed and unsigned multiply.
    run_op("mult_m1x2",  3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("multu_fx2",  3'b001, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("mult_maxmin", 3'b000, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0);

    // Divide, including sign rules, divide by zero and MIN/-1.
    run_op("div_m7d2",   3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_7dm2",   3'b010, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu_100d7", 3'b011, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);
    run_op("div_minm1",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_by0",   3'b011, 32'h1234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1'b0);
    run_op("div_m7by0",  3'b010, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);

    // Start while busy must be ignored.
    run_op("multu_inj",  3'b001, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, 1'b1);

    // MTHI / MTLO: single-cycle writes, no busy, no done.
    op = 3'b100; src_a = 32'hA5A5A5A5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mthi_val", {hi, lo}, {32'hA5A5A5A5, exp_lo});
    chk("mthi_busy", 64'({busy, done}), 64'd0);
    exp_hi = 32'hA5A5A5A5;
    op = 3'b101; src_a = 32'h5A5A5A5A; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mtlo_val", {hi, lo}, {exp_hi, 32'h5A5A5A5A});
    exp_lo = 32'h5A5A5A5A;
    tick();
    chk("mtlo_nodone", 64'({busy, done}), 64'd0);

    // Flush at CALC cycle 10.
    op = 3'b001; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("flush_nodone", 64'(done_cnt), 64'd0);
    chk("flush_hilo", {hi, lo}, {exp_hi, exp_lo});

    // Flush beats start in the same cycle.
    op = 3'b100; src_a = 32'h12345678; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flstart_mthi", {hi, lo}, {exp_hi, exp_lo});
    op = 3'b000; src_a = 32'h3; src_b = 32'h3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flstart_mult", 64'(busy), 64'd0);

    // Flush in the FIX cycle suppresses the write.
    op = 3'b001; src_a = 32'h10; src_b = 32'h10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("fix_busy", 64'({busy, done}), 64'b10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fix_flush", 64'({busy, done}), 64'd0);
    chk("fix_hilo", {hi, lo}, {exp_hi, exp_lo});

    // Reset in the middle of CALC.
    op = 3'b011; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_hilo", {hi, lo}, 64'd0);
    chk("rstmid_ctl", 64'({busy, done}), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("divu_after", 3'b011, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
